mdu_seq_ctrl: RTL
=================

Name: mdu_seq_ctrl

Overview:
Sequencer for the iterative multiply/divide unit in the EX stage. Operands come from the ALU operand-source selection (alu_src1/alu_src2). The block latches one RV64M operation under a valid/ready handshake and runs a radix-2 shift-add multiplier or restoring divider over N cycles. It then applies sign correction and holds the result until EX accepts it. Pipeline flush aborts any in-flight operation.

Parameters:
XLEN, 64, operand/result width; W-variants use XLEN/2.
FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow bypass CALC.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
flush  input  1  abort current op (branch/exception); highest priority after rst
in_valid  input  1  op request from EX
in_ready  output  1  high only in IDLE and not flush
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
is_word  input  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW)
src1  input  XLEN  operand 1 (alu_src1)
src2  input  XLEN  operand 2 (alu_src2)
out_valid  output  1  result available
out_ready  input  1  EX consumes result
result  output  XLEN  final result
busy  output  1  state != IDLE; used by hazard logic to stall

Behaviour:
- Clocking/reset: single clock clk; reset rst is synchronous, active-high. On rst: state=IDLE, out_valid=0, result=0, busy=0, counter=0, operand regs=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. When in_valid & in_ready:
  - latch op and is_word.
  - Compute absolute values of the operands for signed ops.
  - Record the result sign.
  - Go to CALC with counter=N-1, where N=XLEN (is_word ? 32 : 64).
- W operands:
  - Signed W ops sign-extend src[31:0].
  - DIVUW/REMUW zero-extend.
  - MULW uses the low 32 bits.
- CALC: one iteration per cycle.
  - mul: 2*XLEN product register, shift-add on LSB of the multiplier.
  - div: 2*XLEN remainder register, trial subtract, quotient bit shifted in.
  - Counter decrements each cycle; at counter==0 go to FIX.
- FIX (1 cycle):
  - negate the product/quotient/remainder per the recorded sign; remainder takes the dividend sign.
  - select high/low half: MULH*, high; MUL, low.
  - W ops sign-extend bit 31 into result.
  - Go to DONE.
- DONE: out_valid=1 and result stable. On out_ready go to IDLE with out_valid=0 on the next cycle. No new request is accepted in the same cycle as the result handoff.
- Latency: the handshake occurs in cycle T. out_valid first rises in cycle T+N+2: N CALC cycles, 1 FIX cycle, then DONE.
- Special cases, FAST_SPECIAL=1: go IDLE->DONE directly, with out_valid at T+1.
  - divide by zero: quotient = all ones; remainder = dividend (W: sign-extended low 32).
  - signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - With FAST_SPECIAL=0, the iterative path must produce identical values.
- flush:
  - From any state: next cycle state=IDLE, out_valid=0, busy=0, counter=0.
  - flush with in_valid in the same cycle: the request is not accepted.
- rst during CALC: same as flush plus result=0.
- in_valid while busy: ignored (in_ready=0); the requester holds.
- out_ready while not out_valid: no effect.
- result holds its last value outside DONE; verify only when out_valid=1.

Decomposition:
- Shared package: op encodings (MDU_MUL..MDU_REMU), state encoding, XLEN constant, special-value constants (all-ones, most-negative).
- One sub-module, mdu_iter_core: combinational single-step shift-add / trial-subtract datapath. The controller owns all registers, counter and FSM.

Test Plan:
1. MUL src1=3, src2=-5 (0xFFFF_FFFF_FFFF_FFFB) -> result 0xFFFF_FFFF_FFFF_FFF1; out_valid first high 66 cycles after handshake.
2. MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE. Then DIVW src1=0x0000_0000_8000_0000, src2=2 -> result 0xFFFF_FFFF_C000_0000; latency 34.
3. Special values:
   - DIV src1=7, src2=0 -> result 0xFFFF_FFFF_FFFF_FFFF at T+1.
   - REM src1=7, src2=0 -> 7.
   - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
   - REM 0x8000_0000_0000_0000 % -1 -> 0.
4. REM src1=-7, src2=2 -> -1 (0xFFFF_FFFF_FFFF_FFFF). REMU src1=-7, src2=2 -> 1.
5. Backpressure and flush:
   - Hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
   - Assert flush at CALC cycle 20 -> busy=0 next cycle, no out_valid; a following MUL 6*7 returns 42.
6. Reset: assert rst mid-CALC together with in_valid -> all outputs 0 next cycle, request not accepted; first post-reset op (DIVU 100/7 -> 14) is correct.

Source files
------------

// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer: operation
// encodings, FSM state encoding, default width and special-value constants.
package mdu_seq_ctrl_pkg;

  localparam int unsigned MDU_XLEN = 64;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam logic [MDU_XLEN-1:0] MDU_ALL_ONES   = '1;
  localparam logic [MDU_XLEN-1:0] MDU_MOST_NEG   = {1'b1, {(MDU_XLEN-1){1'b0}}};
  localparam logic [MDU_XLEN-1:0] MDU_MOST_NEG_W = {{(MDU_XLEN/2+1){1'b1}}, {(MDU_XLEN/2-1){1'b0}}};

endpackage

// File: rtl/mdu_seq_ctrl_iter.sv
// mdu_iter_core: one combinational iteration of the unsigned datapath.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i    : {hi, lo} product / {remainder, dividend-quotient} register
//   b_i      : multiplicand or divisor magnitude
//   acc_o    : register value after this iteration
module mdu_iter_core #(
  parameter int unsigned XLEN = 64
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shl;
  logic [XLEN+1:0] diff;
  logic            unused_diff;

  // diff never exceeds XLEN bits when it is kept, so bit XLEN is don't-care
  assign unused_diff = diff[XLEN];

  always_comb begin
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
    shl  = acc_i[2*XLEN-1:XLEN-1];
    diff = {1'b0, shl} - {2'b00, b_i};
    if (is_div_i) begin
      // keep the trial difference only when it did not borrow
      if (!diff[XLEN+1]) acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else               acc_o = {shl[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: RV64M multiply/divide sequencer (IDLE -> CALC -> FIX -> DONE).
//   clk, rst            : clock, synchronous active-high reset
//   flush               : abort any in-flight operation
//   in_valid/in_ready   : request handshake (op, is_word, src1, src2)
//   out_valid/out_ready : result handshake (result)
//   busy                : high whenever the sequencer is not IDLE
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = MDU_XLEN,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned AW   = 2 * XLEN;
  localparam int unsigned CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MOST_NEG_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{(XLEN-HALF){v[HALF-1]}}, v};
  endfunction

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d, op_in;
  logic            word_q, word_d, neg_q, neg_d;
  logic [AW-1:0]   acc_q, acc_d, core_acc, mul_neg;
  logic [XLEN-1:0] b_q, b_d, result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, busy_q;
  logic            unused_mul_lo;

  logic            in_div, in_rem, sgn_div, sgn_a, sgn_b, neg_a, neg_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, spec_res, fix_res, q_v, r_v;

  assign unused_mul_lo = ^mul_neg[XLEN-1:0];

  // Operand extension, magnitudes, result sign and special-case detection
  always_comb begin
    op_in   = mdu_op_e'(op);
    in_div  = op[2];
    in_rem  = op[2] & op[1];
    sgn_div = (op_in == MDU_DIV) || (op_in == MDU_REM);
    sgn_a   = sgn_div || (op_in == MDU_MULH) || (op_in == MDU_MULHSU);
    sgn_b   = sgn_div || (op_in == MDU_MULH);
    ext_a   = src1;
    ext_b   = src2;
    if (is_word) begin
      ext_a = sgn_div ? sext_half(src1[HALF-1:0]) : {{(XLEN-HALF){1'b0}}, src1[HALF-1:0]};
      ext_b = sgn_div ? sext_half(src2[HALF-1:0]) : {{(XLEN-HALF){1'b0}}, src2[HALF-1:0]};
    end
    neg_a    = sgn_a & ext_a[XLEN-1];
    neg_b    = sgn_b & ext_b[XLEN-1];
    mag_a    = neg_a ? -ext_a : ext_a;
    mag_b    = neg_b ? -ext_b : ext_b;
    div_zero = in_div & (ext_b == '0);
    div_ovf  = in_div & sgn_div & (ext_a == (is_word ? MOST_NEG_W : MOST_NEG)) & (ext_b == '1);
    special  = FAST_SPECIAL & (div_zero | div_ovf);
    if (in_rem) spec_res = div_zero ? (is_word ? sext_half(src1[HALF-1:0]) : src1) : '0;
    else        spec_res = div_zero ? '1 : ext_a;
  end

  // Sign correction and half selection applied in FIX
  always_comb begin
    mul_neg = -acc_q;
    q_v     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_v     = neg_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    unique case (op_q)
      MDU_MUL:                        fix_res = word_q ? sext_half(acc_q[XLEN-1:HALF]) : acc_q[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = neg_q ? mul_neg[AW-1:XLEN] : acc_q[AW-1:XLEN];
      MDU_DIV, MDU_DIVU:              fix_res = word_q ? sext_half(q_v[HALF-1:0]) : q_v;
      default:                        fix_res = word_q ? sext_half(r_v[HALF-1:0]) : r_v;
    endcase
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (core_acc)
  );

  // State register (with registered status outputs)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Output / datapath next-value logic
  always_comb begin
    in_ready = (state_q == ST_IDLE) & ~flush;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d   = op_in;
          word_d = is_word;
          b_d    = mag_b;
          // word dividends start at the top of the low half so N steps consume them
          acc_d  = {{XLEN{1'b0}}, (in_div && is_word) ? (mag_a << HALF) : mag_a};
          neg_d  = in_rem ? neg_a : ((neg_a ^ neg_b) & ~div_zero);
          cnt_d  = is_word ? CW'(HALF - 1) : CW'(XLEN - 1);
          if (special) begin
            result_d = spec_res;
            cnt_d    = '0;
          end
        end
      end
      ST_CALC: begin
        acc_d = core_acc;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      ST_FIX:  result_d = fix_res;
      default: ;
    endcase
    if (flush) cnt_d = '0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MDU_MUL;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule
